// File: rtl/button_press_decoder.sv
// Classifies debounced button gestures into short, double and long presses,
// each reported as a registered one-cycle pulse.
module button_press_decoder #(
    parameter int LONG_CYCLES = 20,
    parameter int DCLICK_GAP  = 8,
    parameter int CNT_W       = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_in,
    output logic short_press,
    output logic double_press,
    output logic long_press,
    output logic busy
);

    typedef enum logic [2:0] {
        IDLE,
        PRESS1,
        HOLD,
        WAIT_GAP,
        PRESS2
    } state_t;

    localparam logic [CNT_W-1:0] LONG_TH = CNT_W'(LONG_CYCLES);
    localparam logic [CNT_W-1:0] GAP_TH  = CNT_W'(DCLICK_GAP);
    localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
    logic             btn_q;
    logic             rise;
    logic             short_q, short_d;
    logic             double_q, double_d;
    logic             long_q, long_d;
    logic             busy_q, busy_d;

    assign rise    = btn_in & ~btn_q;
    assign cnt_inc = cnt_q + ONE;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        short_d  = 1'b0;
        double_d = 1'b0;
        long_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (rise) begin
                    state_d = PRESS1;
                    cnt_d   = ONE;
                end
            end
            PRESS1: begin
                if (btn_in) begin
                    cnt_d = cnt_inc;
                    if (cnt_inc == LONG_TH) begin
                        long_d  = 1'b1;
                        state_d = HOLD;
                    end
                end else begin
                    // This low sample is the first sample of the gap.
                    state_d = WAIT_GAP;
                    cnt_d   = ONE;
                end
            end
            HOLD: begin
                if (!btn_in) state_d = IDLE;
            end
            WAIT_GAP: begin
                if (btn_in) begin
                    state_d = PRESS2;
                end else begin
                    cnt_d = cnt_inc;
                    if (cnt_inc == GAP_TH) begin
                        short_d = 1'b1;
                        state_d = IDLE;
                    end
                end
            end
            PRESS2: begin
                if (!btn_in) begin
                    double_d = 1'b1;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    // Reset also captures the current level so a button held through reset
    // does not look like a fresh press.
    always_ff @(posedge clk) begin
        btn_q <= btn_in;
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            short_q  <= 1'b0;
            double_q <= 1'b0;
            long_q   <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            short_q  <= short_d;
            double_q <= double_d;
            long_q   <= long_d;
            busy_q   <= busy_d;
        end
    end

    assign short_press  = short_q;
    assign double_press = double_q;
    assign long_press   = long_q;
    assign busy         = busy_q;

endmodule

// File: tb/tb_button_press_decoder.sv
// Bench for button_press_decoder: directed gestures plus random level runs,
// compared cycle by cycle with a run-length based gesture model.
module tb_button_press_decoder;

    localparam int LC = 20;
    localparam int DG = 8;

    logic clk = 1'b0;
    logic rst;
    logic btn_in;
    logic short_press, double_press, long_press, busy;

    always #5 clk = ~clk;

    button_press_decoder #(
        .LONG_CYCLES(LC),
        .DCLICK_GAP (DG),
        .CNT_W      (16)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .btn_in      (btn_in),
        .short_press (short_press),
        .double_press(double_press),
        .long_press  (long_press),
        .busy        (busy)
    );

    int n_cmp = 0;
    int n_err = 0;

    // Gesture model: presses seen in the gesture, length of the first high
    // run, length of the gap after it, and whether the long press was issued.
    int         presses = 0;
    int         hi_run = 0;
    int         lo_run = 0;
    bit         fired = 0;
    bit         prev = 0;
    logic [3:0] exp_v = '0;

    int obs_s, obs_d, obs_l, obs_b;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model(input bit b, input bit r);
        bit s, d, l;
        s = 0; d = 0; l = 0;
        if (r) begin
            presses = 0;
        end else if (b) begin
            if (presses == 0) begin
                if (!prev) begin
                    presses = 1; hi_run = 1; lo_run = 0; fired = 0;
                end
            end else if (presses == 1 && !fired) begin
                if (lo_run == 0) begin
                    hi_run++;
                    if (hi_run == LC) begin
                        l = 1; fired = 1;
                    end
                end else begin
                    presses = 2;
                end
            end
        end else begin
            if (presses == 1 && fired) begin
                presses = 0;
            end else if (presses == 1) begin
                lo_run++;
                if (lo_run == DG) begin
                    s = 1; presses = 0;
                end
            end else if (presses == 2) begin
                d = 1; presses = 0;
            end
        end
        prev  = b;
        exp_v = {s, d, l, (presses != 0)};
    endtask

    task automatic cyc(input bit b, input bit r);
        btn_in = b;
        rst    = r;
        @(posedge clk);
        model(b, r);
        @(negedge clk);
        chk("outs{s,d,l,busy}", {28'd0, short_press, double_press, long_press, busy}, {28'd0, exp_v});
        obs_s += int'(short_press);
        obs_d += int'(double_press);
        obs_l += int'(long_press);
        obs_b += int'(busy);
    endtask

    task automatic run(input bit b, input int n);
        repeat (n) cyc(b, 1'b0);
    endtask

    task automatic clr_obs();
        obs_s = 0; obs_d = 0; obs_l = 0; obs_b = 0;
    endtask

    initial begin
        bit lvl;
        int n;
        clr_obs();

        // Reset state
        cyc(1'b0, 1'b1);
        cyc(1'b0, 1'b1);
        chk("reset_outs", {28'd0, short_press, double_press, long_press, busy}, 32'd0);

        // 1: held through reset
        clr_obs();
        cyc(1'b1, 1'b1);
        cyc(1'b1, 1'b1);
        run(1'b1, 30);
        run(1'b0, 10);
        chk("s1_pulses", obs_s + obs_d + obs_l, 0);
        chk("s1_busy", obs_b, 0);

        // 2: single short press
        clr_obs();
        run(1'b1, 5);
        run(1'b0, 20);
        chk("s2_short", obs_s, 1);
        chk("s2_double", obs_d, 0);
        chk("s2_long", obs_l, 0);

        // 3: double press
        clr_obs();
        run(1'b1, 5);
        run(1'b0, 3);
        run(1'b1, 4);
        run(1'b0, 10);
        chk("s3_double", obs_d, 1);
        chk("s3_short", obs_s, 0);
        chk("s3_long", obs_l, 0);

        // 4: long press held past threshold
        clr_obs();
        run(1'b1, 30);
        chk("s4_busy_held", busy, 1);
        run(1'b0, 10);
        chk("s4_long", obs_l, 1);
        chk("s4_other", obs_s + obs_d, 0);
        chk("s4_busy_released", busy, 0);

        // 5: thresholds LC-1 and LC
        clr_obs();
        run(1'b1, LC - 1);
        run(1'b0, 10);
        chk("s5a_short", obs_s, 1);
        chk("s5a_long", obs_l, 0);
        clr_obs();
        run(1'b1, LC);
        run(1'b0, 10);
        chk("s5b_long", obs_l, 1);
        chk("s5b_short", obs_s, 0);

        // Gap of DG-1 lows then high still forms a double press
        clr_obs();
        run(1'b1, 3);
        run(1'b0, DG - 1);
        run(1'b1, 2);
        run(1'b0, 10);
        chk("gap_edge_double", obs_d, 1);
        chk("gap_edge_short", obs_s, 0);

        // 6: reset aborts a pending short press
        clr_obs();
        run(1'b1, 5);
        run(1'b0, 4);
        cyc(1'b0, 1'b1);
        cyc(1'b0, 1'b1);
        run(1'b0, 20);
        chk("s6_short", obs_s, 0);
        chk("s6_busy", busy, 0);

        // Random level runs biased toward the thresholds, with occasional resets
        lvl = 1'b0;
        for (int i = 0; i < 200; i++) begin
            case ($urandom_range(0, 5))
                0: n = LC - 1;
                1: n = LC;
                2: n = DG - 1;
                3: n = DG;
                default: n = $urandom_range(1, 25);
            endcase
            lvl = ~lvl;
            if ($urandom_range(0, 24) == 0) cyc(lvl, 1'b1);
            run(lvl, n);
        end
        run(1'b0, 12);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
